// File: rtl/a7_link_master.sv
// Request-level sequencer for the Microzed-to-Spartan6/Artix7 serial bus link.
// Serializes a five-byte command frame sequence and collects the flagged reply.
module a7_link_master #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096,
  parameter int TOW     = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wrdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rddata,
  output logic [7:0]  rsp_status,
  output logic        rsp_timeout,
  output logic        serial_out,
  input  logic        serial_in,
  output logic [15:0] nsent,
  output logic [15:0] nrcvd
);

  localparam int FLEN = 10 + GAP;
  localparam int BCW  = $clog2(FLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [15:0]       rsp_rddata_r;
  logic [7:0]        rsp_status_r;
  logic              rsp_timeout_r;
  logic              serial_out_r;
  logic [15:0]       nsent_r;
  logic [15:0]       nrcvd_r;
  logic [FLEN-2:0]   tx_sh_r;
  logic [31:0]       cmd_r;
  logic [BCW-1:0]    bit_r;
  logic [2:0]        byte_r;
  logic [TOW-1:0]    tmo_r;
  logic [23:0]       win_r;
  logic [3:0]        rx_cnt_r;
  logic [9:0]        rx_sh_r;

  logic [10:0]       rx_frame_s;
  logic              rx_ok_s;
  logic              rx_flag_s;
  logic [7:0]        rx_byte_s;
  logic [23:0]       win_next_s;

  // Everything after the start bit; the trailing zeros belong to the gap.
  function automatic logic [FLEN-2:0] make_frame(input logic flag, input logic [7:0] d);
    return {flag, d, {GAP{1'b0}}};
  endfunction

  // Decode the frame completing this cycle: flag, data byte, and the two-zero trailer check
  always_comb begin
    rx_frame_s = {rx_sh_r, serial_in};
    rx_flag_s  = rx_frame_s[10];
    rx_byte_s  = rx_frame_s[9:2];
    win_next_s = {win_r[15:0], rx_byte_s};
    if ((rx_cnt_r == 4'd11) && (rx_frame_s[1:0] == 2'b00)) begin
      rx_ok_s = 1'b1;
    end else begin
      rx_ok_s = 1'b0;
    end
  end

  // RX bit collector: hunt for a start bit, then take the 11 bits that follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_r <= 4'd0;
      rx_sh_r  <= 10'd0;
    end else if (rx_cnt_r == 4'd0) begin
      rx_sh_r <= 10'd0;
      if (serial_in) begin
        rx_cnt_r <= 4'd1;
      end
    end else if (rx_cnt_r == 4'd11) begin
      rx_cnt_r <= 4'd0;
      rx_sh_r  <= 10'd0;
    end else begin
      rx_cnt_r <= rx_cnt_r + 4'd1;
      rx_sh_r  <= {rx_sh_r[8:0], serial_in};
    end
  end

  // Main sequencer: TX framing, reply window, timeout, response capture and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_rddata_r  <= 16'h0000;
      rsp_status_r  <= 8'h00;
      rsp_timeout_r <= 1'b0;
      serial_out_r  <= 1'b0;
      nsent_r       <= 16'h0000;
      nrcvd_r       <= 16'h0000;
      tx_sh_r       <= '0;
      cmd_r         <= 32'h0000_0000;
      bit_r         <= '0;
      byte_r        <= 3'd0;
      tmo_r         <= '0;
      win_r         <= 24'h00_0000;
    end else begin
      rsp_valid_r <= 1'b0;
      // A flagged frame always empties the window, whether or not it ends a transaction.
      if (rx_ok_s) begin
        nrcvd_r <= nrcvd_r + 16'd1;
        if (rx_flag_s) begin
          win_r <= 24'h00_0000;
        end else begin
          win_r <= win_next_s;
        end
      end
      case (state_r)
        IDLE: begin
          serial_out_r <= 1'b0;
          if (req_valid && req_ready_r) begin
            state_r      <= SEND;
            req_ready_r  <= 1'b0;
            serial_out_r <= 1'b1;
            tx_sh_r      <= make_frame(1'b0, req_wr ? 8'h02 : 8'h01);
            cmd_r        <= {req_addr, (req_wr ? req_wrdata : 16'h0000)};
            bit_r        <= '0;
            byte_r       <= 3'd0;
          end
        end
        SEND: begin
          if (bit_r == BCW'(FLEN - 1)) begin
            nsent_r <= nsent_r + 16'd1;
            bit_r   <= '0;
            if (byte_r == 3'd4) begin
              state_r      <= WAIT;
              serial_out_r <= 1'b0;
              tmo_r        <= '0;
            end else begin
              byte_r       <= byte_r + 3'd1;
              serial_out_r <= 1'b1;
              tx_sh_r      <= make_frame(byte_r == 3'd3, cmd_r[31:24]);
              cmd_r        <= {cmd_r[23:0], 8'h00};
            end
          end else begin
            bit_r        <= bit_r + BCW'(1);
            serial_out_r <= tx_sh_r[FLEN-2];
            tx_sh_r      <= {tx_sh_r[FLEN-3:0], 1'b0};
          end
        end
        WAIT: begin
          serial_out_r <= 1'b0;
          // A reply landing on the timeout cycle still wins.
          if (rx_ok_s && rx_flag_s) begin
            state_r       <= DONE;
            rsp_valid_r   <= 1'b1;
            rsp_timeout_r <= 1'b0;
            rsp_rddata_r  <= win_next_s[23:8];
            rsp_status_r  <= win_next_s[7:0];
          end else if (tmo_r == TOW'(TIMEOUT - 1)) begin
            state_r       <= DONE;
            rsp_valid_r   <= 1'b1;
            rsp_timeout_r <= 1'b1;
            rsp_rddata_r  <= 16'h0000;
            rsp_status_r  <= 8'hFF;
          end else begin
            tmo_r <= tmo_r + TOW'(1);
          end
        end
        DONE: begin
          serial_out_r <= 1'b0;
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
        end
        default: begin
          serial_out_r <= 1'b0;
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rddata  = rsp_rddata_r;
  assign rsp_status  = rsp_status_r;
  assign rsp_timeout = rsp_timeout_r;
  assign serial_out  = serial_out_r;
  assign nsent       = nsent_r;
  assign nrcvd       = nrcvd_r;

endmodule

// File: tb/tb_a7_link_master.sv
// Directed bench for a7_link_master: TX frame capture, scripted replies, timeout and reset abort.
module tb_a7_link_master;

  localparam int GAP     = 2;
  localparam int TIMEOUT = 4096;
  localparam int TOW     = 13;
  localparam int NB      = 5 * (10 + GAP);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wrdata = 16'h0000;
  logic        serial_in = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rddata;
  logic [7:0]  rsp_status;
  logic        rsp_timeout;
  logic        serial_out;
  logic [15:0] nsent;
  logic [15:0] nrcvd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int cyc_ref = 0;
  int acc0 = 0;
  bit rdy_bad = 1'b0;
  bit seen = 1'b0;
  logic [NB-1:0] txb;

  a7_link_master #(.GAP(GAP), .TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata), .rsp_status(rsp_status),
    .rsp_timeout(rsp_timeout), .serial_out(serial_out), .serial_in(serial_in),
    .nsent(nsent), .nrcvd(nrcvd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_tx(input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic [7:0] b [5];
    logic [NB-1:0] v;
    b[0] = wr ? 8'h02 : 8'h01;
    b[1] = a[15:8];
    b[2] = a[7:0];
    b[3] = wr ? d[15:8] : 8'h00;
    b[4] = wr ? d[7:0] : 8'h00;
    v = '0;
    for (int i = 0; i < 5; i++) v = {v[NB-(10+GAP)-1:0], 1'b1, (i == 4), b[i], {GAP{1'b0}}};
    return v;
  endfunction

  task automatic start_req(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic hold);
    check_val("idle_line", {serial_out, req_ready}, 2'b01);
    req_wr = wr; req_addr = a; req_wrdata = d; req_valid = 1'b1;
    @(negedge clk);
    if (!hold) begin
      req_valid = 1'b0; req_wr = ~wr; req_addr = 16'hDEAD; req_wrdata = 16'hBEEF;
    end
    rdy_bad = 1'b0;
  endtask

  task automatic capture_tx(output logic [NB-1:0] v);
    for (int i = NB - 1; i >= 0; i--) begin
      v[i] = serial_out;
      if (req_ready) rdy_bad = 1'b1;
      if (i > 0) @(negedge clk);
    end
    cyc_ref = cyc;
  endtask

  task automatic rx_frame(input logic flag, input logic [7:0] d, input logic [1:0] z);
    logic [11:0] f;
    f = {1'b1, flag, d, z};
    for (int i = 11; i >= 0; i--) begin
      serial_in = f[i];
      @(negedge clk);
    end
    serial_in = 1'b0;
  endtask

  task automatic finish_rsp(input string tag, input logic to, input logic [15:0] rd,
                            input logic [7:0] st, input int exp_lat);
    bit got;
    int lat;
    got = 1'b0;
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      if (req_ready) rdy_bad = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - cyc_ref;
    check_val({tag, "_seen"}, got, 1);
    check_val({tag, "_rsp"}, {rsp_timeout, rsp_rddata, rsp_status}, {to, rd, st});
    if (exp_lat >= 0) check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy"}, rdy_bad, 0);
    @(negedge clk);
    check_val({tag, "_after"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_outs", {rsp_valid, rsp_timeout, serial_out, rsp_rddata, rsp_status}, 0);
    check_val("rst_cnt", {nsent, nrcvd}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // write with loopback reply
    start_req(1'b1, 16'h0003, 16'h1234, 1'b0);
    capture_tx(txb);
    check_val("t1_tx", txb, exp_tx(1'b1, 16'h0003, 16'h1234));
    @(negedge clk);
    rx_frame(1'b0, 8'h12, 2'b00); rx_frame(1'b0, 8'h34, 2'b00); rx_frame(1'b1, 8'h00, 2'b00);
    finish_rsp("t1", 1'b0, 16'h1234, 8'h00, -1);
    check_val("t1_cnt", {nsent, nrcvd}, {16'd5, 16'd3});

    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // read returning 0xBEEF
    start_req(1'b0, 16'h0001, 16'hFFFF, 1'b0);
    capture_tx(txb);
    check_val("t2_tx", txb, exp_tx(1'b0, 16'h0001, 16'h0000));
    @(negedge clk);
    rx_frame(1'b0, 8'hBE, 2'b00); rx_frame(1'b0, 8'hEF, 2'b00); rx_frame(1'b1, 8'h00, 2'b00);
    finish_rsp("t2", 1'b0, 16'hBEEF, 8'h00, -1);
    check_val("t2_cnt", {nsent, nrcvd}, {16'd5, 16'd3});

    // silent line: timeout after exactly TIMEOUT cycles in WAIT
    start_req(1'b0, 16'h0042, 16'h0000, 1'b0);
    capture_tx(txb);
    finish_rsp("t3", 1'b1, 16'h0000, 8'hFF, TIMEOUT + 1);
    check_val("t3_cnt", {nsent, nrcvd}, {16'd10, 16'd3});

    // flagged frame completes on the timeout cycle
    start_req(1'b0, 16'h0007, 16'h0000, 1'b0);
    capture_tx(txb);
    repeat (TIMEOUT - 11) @(negedge clk);
    rx_frame(1'b1, 8'h5A, 2'b00);
    finish_rsp("t4", 1'b0, 16'h0000, 8'h5A, TIMEOUT + 1);
    check_val("t4_cnt", {nsent, nrcvd}, {16'd15, 16'd4});

    // malformed frame ahead of a good reply
    start_req(1'b1, 16'hA5C3, 16'h0F0F, 1'b0);
    capture_tx(txb);
    check_val("t5_tx", txb, exp_tx(1'b1, 16'hA5C3, 16'h0F0F));
    @(negedge clk);
    rx_frame(1'b0, 8'hAA, 2'b10);
    rx_frame(1'b0, 8'hC0, 2'b00); rx_frame(1'b0, 8'hDE, 2'b00); rx_frame(1'b1, 8'h07, 2'b00);
    finish_rsp("t5", 1'b0, 16'hC0DE, 8'h07, -1);
    check_val("t5_cnt", {nsent, nrcvd}, {16'd20, 16'd7});

    // req_valid held high across two transactions
    acc0 = acc_cnt;
    start_req(1'b1, 16'h1111, 16'h2222, 1'b1);
    capture_tx(txb);
    check_val("t6a_tx", txb, exp_tx(1'b1, 16'h1111, 16'h2222));
    @(negedge clk);
    rx_frame(1'b0, 8'h33, 2'b00); rx_frame(1'b0, 8'h44, 2'b00); rx_frame(1'b1, 8'h01, 2'b00);
    finish_rsp("t6a", 1'b0, 16'h3344, 8'h01, -1);
    check_val("t6_acc1", acc_cnt - acc0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    rdy_bad = 1'b0;
    capture_tx(txb);
    check_val("t6b_tx", txb, exp_tx(1'b1, 16'h1111, 16'h2222));
    @(negedge clk);
    rx_frame(1'b0, 8'h55, 2'b00); rx_frame(1'b0, 8'h66, 2'b00); rx_frame(1'b1, 8'h02, 2'b00);
    finish_rsp("t6b", 1'b0, 16'h5566, 8'h02, -1);
    repeat (5) @(negedge clk);
    check_val("t6_acc2", acc_cnt - acc0, 2);
    check_val("t6_cnt", {nsent, nrcvd}, {16'd30, 16'd13});

    // reset in the middle of byte 2 (addr low 0xFF, so the line is high there)
    start_req(1'b1, 16'h00FF, 16'h0000, 1'b0);
    repeat (29) @(negedge clk);
    check_val("t7_pre", serial_out, 1);
    rst_n = 1'b0;
    #1;
    check_val("t7_abort", {serial_out, req_ready, nsent, nrcvd}, {1'b0, 1'b1, 16'd0, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_val("t7_norsp", seen, 0);

    // normal transaction after the abort
    start_req(1'b0, 16'h0003, 16'h0000, 1'b0);
    capture_tx(txb);
    check_val("t8_tx", txb, exp_tx(1'b0, 16'h0003, 16'h0000));
    @(negedge clk);
    rx_frame(1'b0, 8'h12, 2'b00); rx_frame(1'b0, 8'h34, 2'b00); rx_frame(1'b1, 8'h00, 2'b00);
    finish_rsp("t8", 1'b0, 16'h1234, 8'h00, -1);
    check_val("t8_cnt", {nsent, nrcvd}, {16'd5, 16'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
